// File: rtl/vga_pkg.sv
// Shared VGA colour definitions: word width, RGB field offsets, default palette and blink phases.
package vga_pkg;

  localparam int unsigned COLOR_W = 12;
  localparam int unsigned R_LSB   = 8;
  localparam int unsigned G_LSB   = 4;
  localparam int unsigned B_LSB   = 0;

  localparam logic [11:0] COLOR_BLACK  = 12'h000;
  localparam logic [11:0] COLOR_CREAM  = 12'hFF7;
  localparam logic [11:0] COLOR_ORANGE = 12'hD50;
  localparam logic [11:0] COLOR_WHITE  = 12'hFFF;

  typedef enum logic {
    PhaseOn  = 1'b0,
    PhaseOff = 1'b1
  } blink_phase_e;

  // Power-up palette: the legacy fixed 4-entry colour table, black beyond it.
  function automatic logic [11:0] default_color(input int unsigned idx);
    unique case (idx)
      0:       default_color = COLOR_BLACK;
      1:       default_color = COLOR_CREAM;
      2:       default_color = COLOR_ORANGE;
      3:       default_color = COLOR_WHITE;
      default: default_color = COLOR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/blink_timer.sv
// Counts frame_tick pulses and toggles the blink phase every BLINK_FRAMES ticks.
module blink_timer #(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_tick,
  output vga_pkg::blink_phase_e blink_phase
);
  import vga_pkg::*;

  localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [CntW-1:0] cnt_q;
  blink_phase_e    phase_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= PhaseOn;
    end else if (frame_tick) begin
      if (cnt_q == CntW'(BLINK_FRAMES - 1)) begin
        cnt_q   <= '0;
        phase_q <= (phase_q == PhaseOn) ? PhaseOff : PhaseOn;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign blink_phase = phase_q;

endmodule

// File: rtl/palette_lut_rgb.sv
// Registered, writable colour palette mapping a display code to packed RGB, with blink and
// blanking; one cycle of latency, a new code every cycle.
module palette_lut_rgb #(
  parameter int unsigned          CODE_W       = 3,
  parameter int unsigned          NUM_ENTRIES  = 8,
  parameter int unsigned          COLOR_W      = vga_pkg::COLOR_W,
  parameter int unsigned          BLINK_FRAMES = 30,
  parameter logic [COLOR_W-1:0]   BLINK_COLOR  = COLOR_W'(vga_pkg::COLOR_BLACK)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               video_on,
  input  logic [CODE_W-1:0]  code_in,
  input  logic               frame_tick,
  input  logic               wr_en,
  input  logic [CODE_W-1:0]  wr_addr,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               wr_blink,
  output logic [COLOR_W-1:0] color_out,
  output logic               color_valid
);
  import vga_pkg::*;

  logic [COLOR_W-1:0]     pal_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] blink_q;
  logic [COLOR_W-1:0]     color_q, color_d;
  logic                   valid_q;
  blink_phase_e           blink_phase;

  logic                   wr_in_range, code_in_range, bypass;
  logic [CODE_W-1:0]      rd_idx;
  logic [COLOR_W-1:0]     entry_color;
  logic                   entry_blink;

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .blink_phase(blink_phase)
  );

  assign wr_in_range   = 32'(wr_addr) < NUM_ENTRIES;
  assign code_in_range = 32'(code_in) < NUM_ENTRIES;
  assign bypass        = wr_en && wr_in_range && (wr_addr == code_in);
  assign rd_idx        = code_in_range ? code_in : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        pal_q[i] <= COLOR_W'(default_color(i));
      end
      blink_q <= '0;
    end else if (wr_en && wr_in_range) begin
      pal_q[wr_addr]   <= wr_data;
      blink_q[wr_addr] <= wr_blink;
    end
  end

  // Write-first: a same-cycle write to the code being looked up wins over stored contents.
  always_comb begin
    entry_color = pal_q[rd_idx];
    entry_blink = blink_q[rd_idx];
    if (bypass) begin
      entry_color = wr_data;
      entry_blink = wr_blink;
    end
    color_d = '0;
    if (video_on && code_in_range) begin
      if (entry_blink && (blink_phase == PhaseOff)) begin
        color_d = BLINK_COLOR;
      end else begin
        color_d = entry_color;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      color_q <= '0;
      valid_q <= 1'b0;
    end else begin
      color_q <= color_d;
      valid_q <= video_on;
    end
  end

  assign color_out   = color_q;
  assign color_valid = valid_q;

endmodule

// File: doc/palette_lut_rgb.md
Name: palette_lut_rgb

Overview:
- Registered, software-programmable colour palette for the VGA pixel path; maps a per-pixel display code to a packed 12-bit RGB value (4 bits per channel, R in [11:8]).
- Generalises the fixed 4-entry display-code colour table: parametrised depth and width, runtime writes, per-entry blink, and blanking.
- Sits between the pixel-code generator and the VGA RGB output registers.

Parameters:
- CODE_W, 3: display-code and palette-address width.
- NUM_ENTRIES, 8: implemented entries, must be <= 2**CODE_W. Codes >= NUM_ENTRIES are out-of-range.
- COLOR_W, 12: colour word width.
- BLINK_FRAMES, 30: frame_tick pulses per blink half-period, must be >= 1.
- BLINK_COLOR, 12'h000: colour substituted during the blink-off phase.

Ports:
- clk  input  1  pixel clock.
- reset  input  1  synchronous, active-high reset.
- video_on  input  1  high inside the visible area; low forces black.
- code_in  input  CODE_W  display code for the current pixel.
- frame_tick  input  1  one-cycle pulse per frame, used for blink timing.
- wr_en  input  1  palette write strobe.
- wr_addr  input  CODE_W  entry to write.
- wr_data  input  COLOR_W  new colour for the entry.
- wr_blink  input  1  new blink-enable bit for the entry.
- color_out  output  COLOR_W  registered RGB.
- color_valid  output  1  registered copy of video_on, aligned with color_out.

Behaviour:
- Reset:
  - Interface is decided: one clock (clk); reset is synchronous and active-high (reset).
  - On reset: color_out = 0 and color_valid = 0.
  - Blink phase = 0 and blink counter = 0.
  - All blink bits are cleared.
  - Palette loads defaults: entry0 = 12'h000, entry1 = 12'hFF7, entry2 = 12'hD50, entry3 = 12'hFFF. Entries 4 and above = 12'h000.
  - Reset has priority over writes and ticks in the same cycle.
  - Reset asserted mid-frame or mid-write discards any in-flight write.
- Latency: exactly 1 cycle from code_in/video_on to color_out/color_valid. No bubbles; a new code is accepted every cycle.
- Output select, evaluated on the cycle's inputs:
  - video_on = 0 -> color_out = 0.
  - video_on = 1 and code >= NUM_ENTRIES -> 0.
  - video_on = 1, entry blink bit = 1 and blink phase = 1 -> BLINK_COLOR.
  - Otherwise -> palette[code].
- Writes:
  - wr_en = 1 updates palette[wr_addr] and blink[wr_addr] at the clock edge.
  - wr_addr >= NUM_ENTRIES: write is ignored.
  - Write-first bypass: if wr_en = 1 and wr_addr == code_in in the same cycle, color_out on the next cycle reflects wr_data and wr_blink.
- Blink timer:
  - Counter increments on each frame_tick.
  - When the counter reaches BLINK_FRAMES-1 and frame_tick = 1: counter -> 0 and phase toggles.
  - Phase changes only on frame_tick; it is independent of video_on.
- State: two phases (ON = 0, OFF = 1) driven by the counter. There is no other FSM.
- Width rules: the counter is sized clog2(BLINK_FRAMES) bits, minimum 1. No truncation on data paths.

Decomposition:
- Shared package vga_pkg holds:
  - COLOR_W and the RGB channel field offsets.
  - Default palette constants: COLOR_BLACK = 12'h000, COLOR_CREAM = 12'hFF7, COLOR_ORANGE = 12'hD50, COLOR_WHITE = 12'hFFF.
  - The blink phase enumeration.
- One sub-module, blink_timer: holds the frame_tick counter and phase register, and outputs blink_phase.
- Palette storage is a flop array in the top module; distributed RAM is not required.

Test Plan:
- Reset then video_on = 1, codes 0,1,2,3,5 on consecutive cycles -> color_out = 000, FF7, D50, FFF, 000, each one cycle later; color_valid = 1.
- video_on = 0 with code 3 -> color_out = 000 and color_valid = 0 on the next cycle; video_on = 1 again -> FFF.
- Write wr_addr = 5, wr_data = 12'h0F0, then present code 5 -> color_out = 0F0. Same-cycle write to addr 2 with code_in = 2, wr_data = 12'h123 -> next color_out = 123.
- Blink test with BLINK_FRAMES = 2:
  - Set blink on entry 1 and hold code 1.
  - Pulse frame_tick twice -> color_out = BLINK_COLOR (000).
  - Two more pulses -> FF7.
  - Code 3 (blink off) stays FFF throughout.
- With NUM_ENTRIES = 6, CODE_W = 3: write to addr 7 is ignored; code 7 -> 000.
- Reset asserted mid-blink with wr_en high -> next cycle color_out = 0, phase = 0, blink bits cleared, palette back to defaults, and the write is dropped.
